// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the packed-BCD arithmetic blocks.
//   BCD_DIGIT_W : width of one BCD digit (nibble)
//   BCD_MAX     : largest legal BCD digit value
//   BCD_CORR    : correction added when a digit sum exceeds BCD_MAX
//   bcd_digit_t : one BCD digit
//   is_bcd()    : true when a nibble holds a legal decimal digit
// ----------------------------------------------------------------------------
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;
   localparam logic [BCD_DIGIT_W-1:0] BCD_MAX  = 4'd9;
   localparam logic [BCD_DIGIT_W-1:0] BCD_CORR = 4'd6;

   typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

   function automatic logic is_bcd(input bcd_digit_t d);
      return (d <= BCD_MAX);
   endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_add.sv
// ----------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD adder with decimal carry in/out.
// Ports:
//   a, b  in  bcd_digit_t  operand digits
//   cin   in  1            decimal carry from the next lower digit
//   s     out bcd_digit_t  corrected sum digit
//   cout  out 1            decimal carry to the next higher digit
//   bad   out 1            a or b is not a legal BCD digit
// ----------------------------------------------------------------------------
module bcd_digit_add
   import bcd_pkg::*;
(
   input  bcd_digit_t a,
   input  bcd_digit_t b,
   input  logic       cin,
   output bcd_digit_t s,
   output logic       cout,
   output logic       bad
);

   // Five bits wide so that sums of illegal nibbles (up to 31) are not lost
   // before the > 9 decision.
   logic [BCD_DIGIT_W:0] raw;

   always_comb begin
      raw  = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
      s    = raw[BCD_DIGIT_W-1:0];
      cout = 1'b0;
      if (raw > {1'b0, BCD_MAX}) begin
         // Adding 6 skips the six unused codes; the bit that would overflow
         // out of the nibble is exactly the decimal carry.
         s    = raw[BCD_DIGIT_W-1:0] + BCD_CORR;
         cout = 1'b1;
      end
      bad  = ~is_bcd(a) | ~is_bcd(b);
   end

endmodule : bcd_digit_add

// File: rtl/bcd_adder4.sv
// ----------------------------------------------------------------------------
// bcd_adder4
// Registered packed-BCD adder: Sum/Carry = A + B in decimal, one cycle latency.
// Ports:
//   clk      in   1          rising-edge clock
//   rst_n    in   1          asynchronous active-low reset
//   A, B     in   4*DIGITS   packed BCD operands, [3:0] = units digit
//   Sum      out  4*DIGITS   registered BCD sum
//   Carry    out  1          registered decimal carry out of the top digit
//   Invalid  out  1          registered flag: some A/B nibble was > 9
// ----------------------------------------------------------------------------
module bcd_adder4
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
)
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] A,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] B,
   output logic [BCD_DIGIT_W*DIGITS-1:0] Sum,
   output logic                        Carry,
   output logic                        Invalid
);

   logic [DIGITS:0]                 carry_chain;
   logic [BCD_DIGIT_W*DIGITS-1:0]   sum_next;
   logic [DIGITS-1:0]               bad_vec;

   assign carry_chain[0] = 1'b0;

   // Ripple chain from the units digit upward.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         bcd_digit_add u_digit (
            .a    (A[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .b    (B[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cin  (carry_chain[gi]),
            .s    (sum_next[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cout (carry_chain[gi+1]),
            .bad  (bad_vec[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Sum     <= '0;
         Carry   <= 1'b0;
         Invalid <= 1'b0;
      end else begin
         Sum     <= sum_next;
         Carry   <= carry_chain[DIGITS];
         Invalid <= |bad_vec;
      end
   end

endmodule : bcd_adder4

// File: tb/tb_bcd_adder4.sv
// ----------------------------------------------------------------------------
// tb_bcd_adder4
// Self-checking bench for bcd_adder4 (DIGITS = 2). Stimulus pushes the
// expected result into a queue; a monitor pops one entry per clock edge after
// reset and compares it with the registered outputs.
// ----------------------------------------------------------------------------
module tb_bcd_adder4;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum;
      logic       carry;
      logic       inv;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] A;
   logic [7:0] B;
   logic [7:0] Sum;
   logic       Carry;
   logic       Invalid;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   bcd_adder4 #(.DIGITS(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .A       (A),
      .B       (B),
      .Sum     (Sum),
      .Carry   (Carry),
      .Invalid (Invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: the result of inputs applied before edge N is visible just
   // after edge N.
   always @(posedge clk) begin
      #1;
      if (rst_n && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (Sum !== e.sum || Carry !== e.carry || Invalid !== e.inv) begin
            failures++;
            $display("FAIL add A=%h B=%h: got Sum=%h Carry=%b Invalid=%b, want Sum=%h Carry=%b Invalid=%b",
                     e.a, e.b, Sum, Carry, Invalid, e.sum, e.carry, e.inv);
         end else begin
            $display("ok   add A=%h B=%h -> Sum=%h Carry=%b Invalid=%b",
                     e.a, e.b, Sum, Carry, Invalid);
         end
      end
   end

   // Drive one operand pair for one cycle and record what must come out.
   task automatic apply(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] es, input logic ec, input logic ei);
      exp_t e;
      @(negedge clk);
      A = a;
      B = b;
      e.a = a; e.b = b; e.sum = es; e.carry = ec; e.inv = ei;
      exp_q.push_back(e);
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (Sum !== 8'h00 || Carry !== 1'b0 || Invalid !== 1'b0) begin
         failures++;
         $display("FAIL %s: got Sum=%h Carry=%b Invalid=%b, want Sum=00 Carry=0 Invalid=0",
                  name, Sum, Carry, Invalid);
      end else begin
         $display("ok   %s: outputs cleared", name);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      A     = 8'h45;
      B     = 8'h27;

      // Reset held across several edges with live operands.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset_hold");

      // Release at a negedge together with the first vector.
      rst_n = 1'b1;
      begin
         exp_t e;
         e.a = 8'h45; e.b = 8'h27; e.sum = 8'h72; e.carry = 1'b0; e.inv = 1'b0;
         exp_q.push_back(e);
      end

      // Directed vectors, expected values worked out by hand.
      apply(8'h45, 8'h27, 8'h72, 1'b0, 1'b0);   // held input -> same output
      apply(8'h99, 8'h01, 8'h00, 1'b1, 1'b0);
      apply(8'h56, 8'h44, 8'h00, 1'b1, 1'b0);
      apply(8'h99, 8'h99, 8'h98, 1'b1, 1'b0);
      apply(8'h08, 8'h05, 8'h13, 1'b0, 1'b0);
      apply(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      apply(8'h50, 8'h50, 8'h00, 1'b1, 1'b0);
      apply(8'h1A, 8'h00, 8'h20, 1'b0, 1'b1);   // A0=10 -> corrected to 0, carry into tens
      apply(8'h10, 8'h00, 8'h10, 1'b0, 1'b0);
      apply(8'h00, 8'hF0, 8'h50, 1'b1, 1'b1);   // B1=15 -> 15+6=21 -> 5, carry
      apply(8'h37, 8'h48, 8'h85, 1'b0, 1'b0);

      // Asynchronous reset between edges: clear without a clock edge.
      apply(8'h99, 8'h99, 8'h98, 1'b1, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset_midcycle");
      @(posedge clk);
      #1;
      check_zero("async_reset_hold_edge");

      // Release and confirm the first post-reset edge takes the new inputs.
      @(negedge clk);
      rst_n = 1'b1;
      A = 8'h12;
      B = 8'h34;
      begin
         exp_t e;
         e.a = 8'h12; e.b = 8'h34; e.sum = 8'h46; e.carry = 1'b0; e.inv = 1'b0;
         exp_q.push_back(e);
      end

      // Every valid operand pair against a plain decimal model.
      for (int ai = 0; ai < 100; ai++) begin
         for (int bi = 0; bi < 100; bi++) begin
            int s;
            s = ai + bi;
            apply(8'(((ai / 10) << 4) | (ai % 10)),
                  8'(((bi / 10) << 4) | (bi % 10)),
                  8'((((s / 10) % 10) << 4) | (s % 10)),
                  (s >= 100), 1'b0);
         end
      end

      // Drain: every issued vector must have been compared.
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_bcd_adder4
